// File: rtl/move_seq.sv
`default_nettype none
// ============================================================================
// Module      : move_seq
// Description : Command sequencer ahead of RemoteComm. Buffers up to DEPTH
//               16-bit Knight commands and issues them one at a time over the
//               send_cmd/cmd_sent handshake. After each command it checks the
//               response byte against ACK. It aborts on a bad response, on an
//               early resp_rdy, or on a per-command timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module move_seq #(
  parameter int unsigned      DEPTH = 16,
  parameter int unsigned      TMO_W = 24,
  parameter logic [TMO_W-1:0] TMO   = 24'd10_000_000,
  parameter logic [7:0]       ACK   = 8'hA5,
  localparam int unsigned     AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [15:0]   wr_data_i,
  input  logic          start_i,
  input  logic          clr_i,
  output logic [15:0]   cmd_o,
  output logic          send_cmd_o,
  input  logic          cmd_sent_i,
  input  logic          resp_rdy_i,
  input  logic [7:0]    resp_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [AW-1:0] cmd_idx_o,
  output logic [AW:0]   count_o,
  output logic          ovfl_o
);

  localparam logic [AW:0]      c_depth_cnt = (AW+1)'(DEPTH);
  localparam logic [TMO_W-1:0] c_tmo_last  = TMO - 1'b1;

  localparam logic [1:0] c_err_resp  = 2'd1;
  localparam logic [1:0] c_err_tmo   = 2'd2;
  localparam logic [1:0] c_err_early = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_SENT = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_DONE      = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  state_t           state_q;
  logic [15:0]      buf_q [DEPTH];
  logic [AW:0]      count_q;
  logic [AW-1:0]    cmd_idx_q;
  logic [15:0]      cmd_q;
  logic             send_cmd_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [1:0]       err_code_q;
  logic             ovfl_q;
  logic [TMO_W-1:0] tmo_q;
  logic             sent_s1_q;
  logic             sent_s2_q;

  logic             idle_like;
  logic             full;
  logic             wr_accept;
  logic             wr_drop_full;
  logic [AW:0]      count_d;
  logic [AW:0]      last_idx;
  logic [AW-1:0]    next_idx;
  logic [15:0]      first_cmd;
  logic             is_last;
  logic             sent_rise;
  logic             tmo_hit;
  logic             resp_ok;

  // Writes are only meaningful while no sequence is running; clr wins.
  assign idle_like    = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign full         = (count_q == c_depth_cnt);
  assign wr_accept    = wr_en_i & ~clr_i & idle_like & ~full;
  assign wr_drop_full = wr_en_i & ~clr_i & idle_like & full;
  assign count_d      = count_q + {{AW{1'b0}}, wr_accept};

  // A write landing in the same cycle as start from an empty buffer is entry 0.
  assign first_cmd    = (count_q == '0) ? wr_data_i : buf_q[0];

  assign last_idx     = count_q - 1'b1;
  assign is_last      = ({1'b0, cmd_idx_q} == last_idx);
  assign next_idx     = cmd_idx_q + 1'b1;

  // cmd_sent is a level; only a fresh low-to-high transition counts.
  assign sent_rise    = sent_s1_q & ~sent_s2_q;
  assign tmo_hit      = (tmo_q == c_tmo_last);
  assign resp_ok      = (resp_i == ACK);

  // Command buffer storage; contents survive start so a list can be replayed.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      buf_q[count_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Sequencer FSM together with every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      send_cmd_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      cmd_idx_q  <= '0;
      count_q    <= '0;
      ovfl_q     <= 1'b0;
      tmo_q      <= '0;
      sent_s1_q  <= 1'b0;
      sent_s2_q  <= 1'b0;
    end else begin
      sent_s1_q  <= cmd_sent_i;
      sent_s2_q  <= sent_s1_q;
      send_cmd_q <= 1'b0;

      if (clr_i) begin
        // Abort and empty the buffer; cmd keeps its last value.
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
        err_code_q <= 2'd0;
        cmd_idx_q  <= '0;
        count_q    <= '0;
        ovfl_q     <= 1'b0;
        tmo_q      <= '0;
      end else begin
        count_q <= count_d;
        if (wr_drop_full) begin
          ovfl_q <= 1'b1;
        end

        case (state_q)
          S_IDLE, S_DONE, S_ERR: begin
            if (start_i) begin
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              err_code_q <= 2'd0;
              cmd_idx_q  <= '0;
              if (count_d == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_SEND;
                busy_q     <= 1'b1;
                send_cmd_q <= 1'b1;
                cmd_q      <= first_cmd;
                tmo_q      <= '0;
              end
            end
          end

          // The send cycle counts towards the per-command timeout.
          S_SEND: begin
            state_q <= S_WAIT_SENT;
            tmo_q   <= tmo_q + 1'b1;
          end

          S_WAIT_SENT: begin
            if (resp_rdy_i) begin
              state_q    <= S_ERR;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= c_err_early;
            end else if (tmo_hit) begin
              state_q    <= S_ERR;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= c_err_tmo;
            end else begin
              tmo_q <= tmo_q + 1'b1;
              if (sent_rise) begin
                state_q <= S_WAIT_RESP;
              end
            end
          end

          // A response arriving on the expiry cycle still counts.
          S_WAIT_RESP: begin
            if (resp_rdy_i) begin
              if (!resp_ok) begin
                state_q    <= S_ERR;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= c_err_resp;
              end else if (is_last) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_SEND;
                cmd_idx_q  <= next_idx;
                cmd_q      <= buf_q[next_idx];
                send_cmd_q <= 1'b1;
                tmo_q      <= '0;
              end
            end else if (tmo_hit) begin
              state_q    <= S_ERR;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= c_err_tmo;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmd_o      = cmd_q;
  assign send_cmd_o = send_cmd_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign cmd_idx_o  = cmd_idx_q;
  assign count_o    = count_q;
  assign ovfl_o     = ovfl_q;

endmodule
`default_nettype wire

// File: tb/tb_move_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_seq
// Description : Directed self-checking bench for move_seq. The bench plays
//               RemoteComm and keeps a small model of the buffer occupancy,
//               the overflow flag and the ordered list of words that must
//               appear on send_cmd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_i;
  logic [15:0] wr_data_i;
  logic        start_i;
  logic        clr_i;
  logic [15:0] cmd_o;
  logic        send_cmd_o;
  logic        cmd_sent_i;
  logic        resp_rdy_i;
  logic [7:0]  resp_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [3:0]  cmd_idx_o;
  logic [4:0]  count_o;
  logic        ovfl_o;

  always #5 clk = ~clk;

  move_seq #(
    .DEPTH (16),
    .TMO_W (24),
    .TMO   (24'd1000),
    .ACK   (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .start_i    (start_i),
    .clr_i      (clr_i),
    .cmd_o      (cmd_o),
    .send_cmd_o (send_cmd_o),
    .cmd_sent_i (cmd_sent_i),
    .resp_rdy_i (resp_rdy_i),
    .resp_i     (resp_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .cmd_idx_o  (cmd_idx_o),
    .count_o    (count_o),
    .ovfl_o     (ovfl_o)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int          mdl_count = 0;
  bit          mdl_ovfl  = 1'b0;
  logic [15:0] exp_q[$];
  int          n_sent = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the bench model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count_o), 32'(mdl_count));
      chk("ovfl", 32'(ovfl_o), 32'(mdl_ovfl));
      chk("busy_vs_flags", 32'(busy_o & (done_o | err_o)), 32'd0);
      chk("done_vs_err", 32'(done_o & err_o), 32'd0);
      if (!err_o) chk("code_without_err", 32'(err_code_o), 32'd0);
      if (send_cmd_o) begin
        n_sent++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_send: got send_cmd with cmd 0x%0h, expected none", cmd_o);
        end else begin
          chk("send_word", 32'(cmd_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d);
    wr_en_i   = 1'b1;
    wr_data_i = d;
    tick();
    wr_en_i   = 1'b0;
    if (mdl_count < 16) mdl_count++;
    else mdl_ovfl = 1'b1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    mdl_count = 0;
    mdl_ovfl  = 1'b0;
    exp_q.delete();
  endtask

  // RemoteComm behaviour for one command, entered on the cycle send_cmd shows.
  // mode 0: full handshake and response r; mode 1: stop in the response wait.
  task automatic serve(input logic [7:0] r, input int mode);
    chk("send_pulse", 32'(send_cmd_o), 32'd1);
    cmd_sent_i = 1'b0;
    tick();
    tick();
    cmd_sent_i = 1'b1;
    tick();
    tick();
    chk("busy_in_wait", 32'(busy_o), 32'd1);
    if (mode == 0) begin
      resp_i     = r;
      resp_rdy_i = 1'b1;
      tick();
      resp_rdy_i = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd"},      32'(cmd_o),      32'd0);
    chk({tag, "_send"},     32'(send_cmd_o), 32'd0);
    chk({tag, "_busy"},     32'(busy_o),     32'd0);
    chk({tag, "_done"},     32'(done_o),     32'd0);
    chk({tag, "_err"},      32'(err_o),      32'd0);
    chk({tag, "_err_code"}, 32'(err_code_o), 32'd0);
    chk({tag, "_cmd_idx"},  32'(cmd_idx_o),  32'd0);
    chk({tag, "_count"},    32'(count_o),    32'd0);
    chk({tag, "_ovfl"},     32'(ovfl_o),     32'd0);
  endtask

  initial begin
    int k;
    rst        = 1'b1;
    wr_en_i    = 1'b0;
    wr_data_i  = '0;
    start_i    = 1'b0;
    clr_i      = 1'b0;
    cmd_sent_i = 1'b1;
    resp_rdy_i = 1'b0;
    resp_i     = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    check_reset_vals("reset");

    // Three commands, all acknowledged.
    wr(16'h2000);
    wr(16'h4002);
    wr(16'h47F4);
    chk("s1_count", 32'(count_o), 32'd3);
    exp_q.push_back(16'h2000);
    exp_q.push_back(16'h4002);
    exp_q.push_back(16'h47F4);
    n_sent = 0;
    pulse_start();
    chk("s1_first_cmd", 32'(cmd_o), 32'h2000);
    for (int i = 0; i < 3; i++) serve(8'hA5, 0);
    chk("s1_done", 32'(done_o), 32'd1);
    chk("s1_err", 32'(err_o), 32'd0);
    chk("s1_busy", 32'(busy_o), 32'd0);
    chk("s1_cmd_idx", 32'(cmd_idx_o), 32'd2);
    repeat (5) tick();
    chk("s1_sends", 32'(n_sent), 32'd3);
    chk("s1_pending", 32'(exp_q.size()), 32'd0);

    // Replay the same list; second command gets a bad response.
    exp_q.push_back(16'h2000);
    exp_q.push_back(16'h4002);
    n_sent = 0;
    pulse_start();
    chk("s2_done_cleared", 32'(done_o), 32'd0);
    serve(8'hA5, 0);
    serve(8'h5A, 0);
    chk("s2_err", 32'(err_o), 32'd1);
    chk("s2_err_code", 32'(err_code_o), 32'd1);
    chk("s2_cmd_idx", 32'(cmd_idx_o), 32'd1);
    chk("s2_done", 32'(done_o), 32'd0);
    repeat (8) tick();
    chk("s2_sends", 32'(n_sent), 32'd2);

    // No response at all: timeout exactly TMO cycles after send_cmd.
    pulse_clr();
    wr(16'h1234);
    exp_q.push_back(16'h1234);
    pulse_start();
    chk("s3_send", 32'(send_cmd_o), 32'd1);
    k = 0;
    while (!err_o && k < 1100) begin
      tick();
      k++;
    end
    chk("s3_tmo_cycles", 32'(k), 32'd1000);
    chk("s3_err_code", 32'(err_code_o), 32'd2);
    chk("s3_busy", 32'(busy_o), 32'd0);
    chk("s3_cmd_hold", 32'(cmd_o), 32'h1234);

    // Seventeen writes into a sixteen-entry buffer.
    pulse_clr();
    for (int i = 0; i < 17; i++) wr(16'(16'hA000 + i));
    chk("s4_count", 32'(count_o), 32'd16);
    chk("s4_ovfl", 32'(ovfl_o), 32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(16'(16'hA000 + i));
    n_sent = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) serve(8'hA5, 0);
    chk("s4_done", 32'(done_o), 32'd1);
    chk("s4_cmd_idx", 32'(cmd_idx_o), 32'd15);
    repeat (3) tick();
    chk("s4_sends", 32'(n_sent), 32'd16);

    // resp_rdy while cmd_sent stays high (no fresh edge) -> early response.
    pulse_clr();
    wr(16'h0C0D);
    exp_q.push_back(16'h0C0D);
    pulse_start();
    repeat (3) tick();
    resp_i     = 8'hA5;
    resp_rdy_i = 1'b1;
    tick();
    resp_rdy_i = 1'b0;
    chk("s5_err", 32'(err_o), 32'd1);
    chk("s5_err_code", 32'(err_code_o), 32'd3);

    // clr while waiting for the response, then start on an empty buffer.
    pulse_clr();
    wr(16'h1111);
    wr(16'h2222);
    exp_q.push_back(16'h1111);
    pulse_start();
    serve(8'h00, 1);
    pulse_clr();
    chk("s6_busy", 32'(busy_o), 32'd0);
    chk("s6_count", 32'(count_o), 32'd0);
    chk("s6_err", 32'(err_o), 32'd0);
    chk("s6_cmd_kept", 32'(cmd_o), 32'h1111);
    n_sent = 0;
    pulse_start();
    chk("s6_empty_done", 32'(done_o), 32'd1);
    chk("s6_empty_busy", 32'(busy_o), 32'd0);
    repeat (4) tick();
    chk("s6_empty_sends", 32'(n_sent), 32'd0);

    // Write and start in the same cycle: start sees the new entry.
    exp_q.push_back(16'hBEEF);
    wr_en_i   = 1'b1;
    wr_data_i = 16'hBEEF;
    start_i   = 1'b1;
    tick();
    wr_en_i   = 1'b0;
    start_i   = 1'b0;
    mdl_count = 1;
    chk("s7_cmd", 32'(cmd_o), 32'hBEEF);
    chk("s7_done_cleared", 32'(done_o), 32'd0);
    serve(8'hA5, 0);
    chk("s7_done", 32'(done_o), 32'd1);
    chk("s7_cmd_idx", 32'(cmd_idx_o), 32'd0);

    // Reset in the middle of a sequence.
    exp_q.push_back(16'hBEEF);
    pulse_start();
    cmd_sent_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    mdl_count  = 0;
    mdl_ovfl   = 1'b0;
    exp_q.delete();
    cmd_sent_i = 1'b1;
    check_reset_vals("s8");
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/move_seq.md
# move_seq

Stimulus-side command sequencer that sits directly upstream of RemoteComm in the Knight's Tour bench and bring-up harness. It buffers a list of 16-bit Knight commands, such as calibrate or move with heading/squares/fanfare, and issues them one at a time over RemoteComm's `send_cmd`/`cmd_sent` handshake. After each command it waits for the DUT response and checks it against the expected acknowledge value. It replaces hand-written per-move wait loops with a replayable sequence plus timeout and error reporting.

## Interface
Parameters:
- `DEPTH`, 16: command buffer entries (power of 2).
- `TMO_W`, 24: width of the response timeout counter.
- `TMO`, 24'd10_000_000: cycles allowed per command (send plus response) before timeout.
- `ACK`, 8'hA5: expected response byte.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: **synchronous, active-high reset.**
- `wr_en` in 1: write `wr_data` into the next buffer entry (honoured only in IDLE).
- `wr_data` in 16: command word, opaque to this block.
- `start` in 1: begin issuing buffered commands from entry 0.
- `clr` in 1: abort any sequence, empty the buffer, return to IDLE.
- `cmd` out 16: command presented to RemoteComm.
- `send_cmd` out 1: one-cycle request to RemoteComm.
- `cmd_sent` in 1: RemoteComm level flag; low after `send_cmd`, high once both bytes are transmitted.
- `resp_rdy` in 1: one-cycle pulse from RemoteComm.
- `resp` in 8: response byte, valid with `resp_rdy`.
- `busy` out 1: sequence in progress.
- `done` out 1: all commands acknowledged; held until `start`, `clr` or `rst`.
- `err` out 1: sequence aborted; held until `start`, `clr` or `rst`.
- `err_code` out 2: 1 = bad response, 2 = timeout, 3 = unexpected `resp_rdy`.
- `cmd_idx` out log2(DEPTH): index of the current (or failing) command.
- `count` out log2(DEPTH)+1: number of buffered entries.
- `ovfl` out 1: sticky flag, set by a write when the buffer is full.

## Operation
- Buffer: `count` increments on each accepted write.
  - A write is accepted only when in IDLE/DONE/ERR and `count < DEPTH`.
  - A write at `count == DEPTH` is dropped and sets `ovfl`.
  - Writes in any other state are dropped silently.
- The buffer is not cleared by `start`, so the same list can be replayed.
- FSM states: IDLE, SEND, WAIT_SENT, WAIT_RESP, DONE, ERR.
  - IDLE/DONE/ERR, `start`:
    - `count == 0`: go to DONE.
    - Otherwise: set `cmd_idx = 0`, clear `done`/`err`/`err_code`, go to SEND.
  - SEND: drive `cmd = buf[cmd_idx]`, pulse `send_cmd` for 1 cycle, clear the timeout counter, go to WAIT_SENT.
  - WAIT_SENT: wait for a registered rising edge of `cmd_sent`, then go to WAIT_RESP.
  - WAIT_RESP, on `resp_rdy`:
    - `resp == ACK` and `cmd_idx == count-1`: go to DONE.
    - `resp == ACK` otherwise: increment `cmd_idx`, go to SEND.
    - `resp != ACK`: go to ERR with code 1.
  - WAIT_SENT or WAIT_RESP: timeout counter reaches `TMO-1` → ERR with code 2. The counter spans both states.
  - `resp_rdy` seen in WAIT_SENT → ERR with code 3.
- `cmd` holds its last value outside SEND so RemoteComm can sample it at any time.
- `busy` = state is SEND, WAIT_SENT or WAIT_RESP.
- Precedence: `rst` > `clr` > `start` > handshake events.
  - `clr` mid-sequence → IDLE, `count = 0`, flags cleared; `cmd` keeps its value.
  - `start` while busy is ignored.

## Timing
- Reset values: `cmd = 0`, `send_cmd = 0`, `busy = 0`, `done = 0`, `err = 0`, `err_code = 0`, `cmd_idx = 0`, `count = 0`, `ovfl = 0`; state IDLE.
- `start` sampled at edge N: SEND at N+1, so `send_cmd` and the new `cmd` are visible at N+1.
- Latency between back-to-back commands: `resp_rdy` at edge M → `send_cmd` at M+1.
- Edge detection: the `cmd_sent` edge is detected one cycle after the flag rises. A `cmd_sent` that is already high and does not drop after `send_cmd` is never seen; it ends in a timeout.
- A `resp_rdy` coincident with timeout expiry takes priority over the timeout.
- A write and `start` in the same cycle: the write is accepted first, and `start` uses the updated `count`.
- `done`/`err` assert the cycle after the deciding edge; `busy` drops in that same cycle.

## Test plan
- Write 8'h? commands {0x2000, 0x4002, 0x47F4}, `start`; model ACKs each → exactly 3 `send_cmd` pulses carrying those words in order, `done = 1`, `cmd_idx = 2`, `err = 0`.
- Second command answered with 0x5A → `err = 1`, `err_code = 1`, `cmd_idx = 1`, no third `send_cmd`.
- `TMO = 1000` with no response → `err_code = 2` exactly 1000 cycles after `send_cmd`.
- Write 17 entries with `DEPTH = 16` → `count = 16`, `ovfl = 1`; 16 commands issued.
- `resp_rdy` pulsed before `cmd_sent` rises → `err_code = 3`.
- `clr` asserted in WAIT_RESP → IDLE next cycle, `count = 0`, `busy = 0`. Then `start` with empty buffer → `done = 1` with no `send_cmd`.
- `rst` mid-sequence → all outputs at their reset values next cycle.
